// File: rtl/mem_stage.sv
// Purpose : memory-access stage between EX/MEM and MEM/WB; aligns stores, extends loads, drives dmem bus.
// Latency : non-memory ops 0 cycles (combinational); accesses 2 + N wait cycles; misaligned 2; timeout TIMEOUT+1 after request.
// Backpres: stall freezes upstream while an access is outstanding; dmem_req is held until dmem_ready or timeout.
//
// Ports:
//   clk, rst            pipeline clock, synchronous active-high reset
//   inflow, in_valid    EX/MEM register contents and its valid bit
//   outflow, out_valid  MEM/WB flow and its valid bit
//   stall               upstream freeze while an access is in flight
//   fwd_data            EX forwarding path (alu_result of the instruction in MEM)
//   dmem_*              single-port data memory bus, req/ready handshake
//   misaligned          one-cycle pulse in RESP when an access was suppressed as misaligned
//   bus_error           one-cycle pulse in RESP when the access timed out

package mem_stage_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;       // 00 byte, 01 half, 10/11 word
        logic       mem_unsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        logic [31:0] pc_incr;
        logic [31:0] immediate;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
    } ex_mem_flow_t;

    typedef struct packed {
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [31:0] pc_incr;
        logic [31:0] immediate;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
    } mem_wb_flow_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  ex_mem_flow_t  inflow,
    input  logic          in_valid,
    output mem_wb_flow_t  outflow,
    output logic          out_valid,
    output logic          stall,
    output logic [31:0]   fwd_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [31:0]   dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic          dmem_ready,
    input  logic [31:0]   dmem_rdata,
    output logic          misaligned,
    output logic          bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // wcnt is 8 bits; a TIMEOUT above 255 truncates here.
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic [31:0] rlat, rlat_nxt;
    logic        err_r, err_nxt;
    logic        mis_r, mis_nxt;

    logic        is_acc;
    logic        is_mis;
    logic        req_c;
    logic        stall_c;
    logic        ovld_c;
    logic [1:0]  boff;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign boff   = inflow.alu_result[1:0];
    assign is_acc = in_valid & (inflow.mem_ctrl.mem_read | inflow.mem_ctrl.mem_write);
    assign is_mis = ((inflow.mem_ctrl.mem_size == 2'b01) & boff[0])
                  | (inflow.mem_ctrl.mem_size[1] & (boff != 2'b00));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
            rlat  <= '0;
            err_r <= 1'b0;
            mis_r <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            rlat  <= rlat_nxt;
            err_r <= err_nxt;
            mis_r <= mis_nxt;
        end
    end

    // ---------------- next state / control ----------------
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        rlat_nxt  = rlat;
        err_nxt   = err_r;
        mis_nxt   = mis_r;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        ovld_c    = 1'b0;
        case (state)
            IDLE: begin
                if (is_acc) begin
                    stall_c = 1'b1;
                    if (is_mis) begin
                        // Suppressed access still spends one stalled cycle so
                        // the error is reported in RESP like any other access.
                        mis_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        req_c = 1'b1;
                        if (dmem_ready) begin
                            rlat_nxt  = dmem_rdata;
                            state_nxt = RESP;
                        end else begin
                            wcnt_nxt  = 8'd1;
                            state_nxt = WAIT;
                        end
                    end
                end else begin
                    ovld_c = in_valid;
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                // A late ready wins over an expiring timeout.
                if (dmem_ready) begin
                    rlat_nxt  = dmem_rdata;
                    state_nxt = RESP;
                end else if ((TIMEOUT != 0) && (wcnt == TO_CNT)) begin
                    rlat_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    wcnt_nxt = wcnt + 8'd1;
                end
            end
            RESP: begin
                ovld_c    = 1'b1;
                state_nxt = IDLE;
                err_nxt   = 1'b0;
                mis_nxt   = 1'b0;
                wcnt_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- store lane alignment ----------------
    always_comb begin
        st_data = inflow.rs2_data;
        st_strb = 4'b1111;
        case (inflow.mem_ctrl.mem_size)
            2'b00: begin
                st_data = {4{inflow.rs2_data[7:0]}};
                st_strb = 4'b0001 << boff;
            end
            2'b01: begin
                st_data = {2{inflow.rs2_data[15:0]}};
                st_strb = boff[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = inflow.rs2_data;
                st_strb = 4'b1111;
            end
        endcase
    end

    // ---------------- load extraction ----------------
    assign ld_shift = rlat >> {boff, 3'b000};

    always_comb begin
        ld_data = rlat;
        case (inflow.mem_ctrl.mem_size)
            2'b00:   ld_data = inflow.mem_ctrl.mem_unsigned ? {24'h0, ld_shift[7:0]}
                                                            : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = inflow.mem_ctrl.mem_unsigned ? {16'h0, ld_shift[15:0]}
                                                            : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = rlat;
        endcase
    end

    // ---------------- MEM/WB flow ----------------
    always_comb begin
        outflow            = '0;
        outflow.alu_result = inflow.alu_result;
        outflow.pc_incr    = inflow.pc_incr;
        outflow.immediate  = inflow.immediate;
        outflow.rd_addr    = inflow.rd_addr;
        outflow.wb_ctrl    = inflow.wb_ctrl;
        if (mis_r | err_r) begin
            outflow.wb_ctrl.reg_write = 1'b0;
        end
        if ((state == RESP) && inflow.mem_ctrl.mem_read && !err_r && !mis_r) begin
            outflow.mem_data = ld_data;
        end
    end

    // ---------------- bus / pipeline outputs ----------------
    // Reset gates the control outputs combinationally so a reset in the
    // middle of a wait drops the request in the same cycle.
    assign fwd_data   = inflow.alu_result;
    assign dmem_addr  = {inflow.alu_result[31:2], 2'b00};
    assign dmem_wdata = st_data;
    assign dmem_req   = req_c & ~rst;
    assign dmem_we    = req_c & inflow.mem_ctrl.mem_write & ~rst;
    assign dmem_wstrb = (req_c & inflow.mem_ctrl.mem_write & ~rst) ? st_strb : 4'b0000;
    assign stall      = stall_c & ~rst;
    assign out_valid  = ovld_c & ~rst;
    assign misaligned = (state == RESP) & mis_r & ~rst;
    assign bus_error  = (state == RESP) & err_r & ~rst;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM and MEM/WB pipeline registers. It consumes the execute-stage flow and drives a single-port data-memory bus with a req/ready handshake. It aligns store data and generates byte strobes, and extracts and extends load data. It stalls the upstream pipeline while an access is outstanding and produces the MEM/WB flow.

## Interface
Parameters:
- TIMEOUT, default 64: maximum wait cycles for `dmem_ready`; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- inflow  in  ex_mem_flow_t  EX/MEM register contents. Fields used: alu_result, rs2_data, rd_addr, pc_incr, immediate, mem_ctrl{MemRead, MemWrite, MemSize[1:0] (00 byte, 01 half, 10 word), MemUnsigned}, wb_ctrl{RegWrite,...}.
- in_valid  in  1  inflow holds a real instruction (not a bubble).
- outflow  out  mem_wb_flow_t  mem_data, alu_result, pc_incr, immediate and rd_addr passthrough, plus wb_ctrl.
- out_valid  out  1  outflow is valid this cycle.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB.
- fwd_data  out  32  equals inflow.alu_result; feeds the EX forwarding MEM path.
- dmem_req, dmem_we  out  1 each  bus request and write enable.
- dmem_addr  out  32  {alu_result[31:2], 2'b00}.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_wstrb  out  4  byte strobes; 0 for loads.
- dmem_ready  in  1  access accepted; read data valid this cycle.
- dmem_rdata  in  32  read word.
- misaligned  out  1  pulse: misaligned access suppressed.
- bus_error  out  1  pulse: access timed out.

## Operation
- An access is `in_valid & (MemRead | MemWrite)`.
- An access is misaligned for a half with addr[0]=1 or a word with addr[1:0]≠0. MemSize=11 is treated as word.
- FSM states are IDLE, WAIT and RESP. The counter `wcnt` is 8 bits. A latch `rlat` holds 32 bits, plus the flags `err_r` and `mis_r`.
- IDLE, no access: passthrough; out_valid=in_valid; stall=0; dmem_req=0.
- IDLE, aligned access: dmem_req=1 and stall=1.
  - If dmem_ready=1: rlat←dmem_rdata, go to RESP.
  - Otherwise: go to WAIT with wcnt←1.
- IDLE, misaligned access: no request; stall=1, mis_r←1, go to RESP.
- WAIT: dmem_req=1 and stall=1; address, data and strobes are held constant because inflow is frozen.
  - If dmem_ready=1: rlat←dmem_rdata, go to RESP.
  - Else if TIMEOUT≠0 and wcnt==TIMEOUT: rlat←0, err_r←1, go to RESP.
  - Otherwise: wcnt++.
  - dmem_ready takes precedence over the timeout in the same cycle.
- RESP: dmem_req=0, stall=0, out_valid=1, misaligned=mis_r, bus_error=err_r. On the next edge: IDLE, flags cleared, wcnt←0.
- Store data and strobes:
  - Byte: wdata = four copies of rs2[7:0]; wstrb = 1<<addr[1:0].
  - Half: wdata = two copies of rs2[15:0]; wstrb = addr[1] ? 1100 : 0011.
  - Word: wdata = rs2; wstrb = 1111.
- Load data: `sh = rlat >> (8*addr[1:0])`.
  - Byte: sign- or zero-extend sh[7:0]; MemUnsigned selects zero-extension.
  - Half: sign- or zero-extend sh[15:0].
  - Word: rlat.
  - mem_data = 0 for stores, non-memory ops, errors and misaligned accesses.
- wb_ctrl.RegWrite is forced to 0 when mis_r or err_r is set.

## Timing
- Reset: state=IDLE, wcnt=0, rlat=0, err_r=mis_r=0.
- While rst=1, these outputs are forced to 0: dmem_req, dmem_we, dmem_wstrb, stall, out_valid, misaligned, bus_error.
- A reset mid-WAIT drops dmem_req in the same cycle; no response is expected afterwards.
- Non-memory instruction: 0 added latency, combinational passthrough.
- Memory access: minimum 2 cycles (request, then RESP); N wait cycles give 2+N.
- Misaligned access: 2 cycles (IDLE stalled, then RESP).
- Timeout: RESP in cycle TIMEOUT+1 after the request cycle.
- stall is deasserted exactly in RESP, so the EX/MEM register advances on the RESP edge. Back-to-back accesses re-enter IDLE with a new inflow.
- A bubble (in_valid=0) never issues dmem_req, even if its mem_ctrl bits are set.

## Test plan
- Word load, zero-wait: alu_result=0x100, rdata=0xDEADBEEF with ready in the request cycle → stall for 1 cycle; next cycle out_valid=1, mem_data=0xDEADBEEF, req=0.
- Signed and unsigned byte load: addr=0x103, rdata=0x80FF_1234 → LB mem_data=0xFFFFFF80; LBU mem_data=0x00000080.
- Half store with 3 wait states: addr=0x202, rs2=0x0000ABCD → wstrb=1100, wdata=0xABCDABCD held constant for 4 request cycles; stall 4 cycles; RESP on cycle 5.
- Misaligned load: LW addr=0x101 → dmem_req stays 0; misaligned=1 in RESP; RegWrite=0; mem_data=0.
- Timeout with TIMEOUT=4, ready never asserted → bus_error=1 in RESP 5 cycles after the request; RegWrite=0. Ready on the same cycle as wcnt==4 → normal completion with no bus_error.
- Reset mid-WAIT: assert rst in wait cycle 2 → dmem_req=0 in that cycle; after release, an ALU instruction passes through with stall=0.
